// File: rtl/par_serial_8_1_pkg.sv
// Shared constants and types for the byte-to-serial converter.
// COM_K28_5 is the idle/alignment character sent during sync and when no data is offered.
package par_serial_8_1_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam logic [BYTE_W-1:0] COM_K28_5 = 8'hBC;

    typedef enum logic {
        SYNC,
        ACTIVE
    } state_e;

endpackage

// File: rtl/par_serial_8_1_bit_cnt_mod8.sv
// Modulo-8 bit counter. It comes out of reset at 7, so the first edge after release is a load edge.
module bit_cnt_mod8 (
    input  logic clk,
    input  logic rst_n,
    output logic wrap
);

    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 3'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 3'd7;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wrap = (cnt_q == 3'd7);

endmodule

// File: rtl/par_serial_8_1.sv
// Serialises bytes MSB-first, one bit per clk. After reset it sends SYNC_COUNT COM bytes,
// then requests a byte every 8 clocks and substitutes COM whenever none is offered.
module par_serial_8_1
    import par_serial_8_1_pkg::*;
#(
    parameter int unsigned       SYNC_COUNT = 4,
    parameter logic [BYTE_W-1:0] COM        = COM_K28_5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] in_data8,
    input  logic              in8,
    output logic              load_req,
    output logic              out_serial,
    output logic              out_com,
    output logic              active
);

    localparam logic [7:0] SYNC_LAST = 8'(SYNC_COUNT - 1);

    logic              load_edge;
    state_e            state_q, state_d;
    logic [BYTE_W-1:0] shreg_q, shreg_d;
    logic              com_q, com_d;
    logic [7:0]        sync_cnt_q, sync_cnt_d;

    bit_cnt_mod8 u_bit_cnt (
        .clk   (clk),
        .rst_n (reset),
        .wrap  (load_edge)
    );

    always_comb begin
        state_d    = state_q;
        shreg_d    = {shreg_q[BYTE_W-2:0], 1'b0};
        com_d      = com_q;
        sync_cnt_d = sync_cnt_q;
        if (load_edge) begin
            unique case (state_q)
                SYNC: begin
                    shreg_d    = COM;
                    com_d      = 1'b1;
                    sync_cnt_d = sync_cnt_q + 8'd1;
                    if (sync_cnt_q == SYNC_LAST) begin
                        state_d = ACTIVE;
                    end
                end
                ACTIVE: begin
                    // Missing data is replaced by COM so the line never stalls.
                    if (in8) begin
                        shreg_d = in_data8;
                        com_d   = 1'b0;
                    end else begin
                        shreg_d = COM;
                        com_d   = 1'b1;
                    end
                end
                default: state_d = SYNC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= SYNC;
            shreg_q    <= '0;
            com_q      <= 1'b0;
            sync_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            com_q      <= com_d;
            sync_cnt_q <= sync_cnt_d;
        end
    end

    assign out_serial = shreg_q[BYTE_W-1];
    assign out_com    = com_q;
    assign active     = (state_q == ACTIVE);
    assign load_req   = load_edge && (state_q == ACTIVE);

endmodule

// File: tb/tb_par_serial_8_1.sv
// Bench for par_serial_8_1: default instance (SYNC_COUNT=4) and a SYNC_COUNT=1 instance
// share stimulus; a slot-based byte model predicts every output bit.
module tb_par_serial_8_1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in_data8 = '0;
    logic       in8 = 1'b0;
    logic [1:0] ser, com, act, lrq;

    int checks = 0;
    int failures = 0;

    // Model: e = edges since reset release, n = bytes started; each byte occupies 8 edges.
    int          e = 0;
    int          n = 0;
    int          sc [2] = '{4, 1};
    logic [7:0]  mbyte [2];
    logic        mcom [2];

    par_serial_8_1 dut (
        .clk        (clk),
        .reset      (reset),
        .in_data8   (in_data8),
        .in8        (in8),
        .load_req   (lrq[0]),
        .out_serial (ser[0]),
        .out_com    (com[0]),
        .active     (act[0])
    );

    par_serial_8_1 #(.SYNC_COUNT(1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .in_data8   (in_data8),
        .in8        (in8),
        .load_req   (lrq[1]),
        .out_serial (ser[1]),
        .out_com    (com[1]),
        .active     (act[1])
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        e = 0;
        n = 0;
        for (int i = 0; i < 2; i++) begin
            mbyte[i] = '0;
            mcom[i]  = 1'b0;
        end
    endtask

    // One rising edge; the model samples inputs exactly as the DUT does, then settle 1ns.
    task automatic step();
        @(posedge clk);
        if (reset) begin
            e++;
            if ((e - 1) % 8 == 0) begin
                for (int i = 0; i < 2; i++) begin
                    if (n < sc[i] || !in8) begin
                        mbyte[i] = 8'hBC;
                        mcom[i]  = 1'b1;
                    end else begin
                        mbyte[i] = in_data8;
                        mcom[i]  = 1'b0;
                    end
                end
                n++;
            end
        end
        #1;
    endtask

    function automatic logic [3:0] exp_vec(int i);
        logic [7:0] b;
        int bp;
        if (e == 0) return 4'b0000;
        b  = mbyte[i];
        bp = 7 - ((e - 1) % 8);
        return {b[bp], mcom[i], (n >= sc[i]), ((e % 8 == 0) && (n >= sc[i]))};
    endfunction

    function automatic logic [3:0] got_vec(int i);
        return {ser[i], com[i], act[i], lrq[i]};
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        #3;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (got_vec(i) !== 4'b0000) begin
                failures++;
                $display("FAIL reset_state dut%0d got=%b exp=0000 (ser,com,act,lrq)", i, got_vec(i));
            end
        end
        #20;
        reset = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (got_vec(i) !== 4'b0000) begin
                failures++;
                $display("FAIL post_release dut%0d got=%b exp=0000", i, got_vec(i));
            end
        end
    endtask

    task automatic test_sync();
        logic [31:0] bits = '0;
        logic        all_com = 1'b1;
        in8 = 1'b0;
        for (int k = 0; k < 32; k++) begin
            in_data8 = 8'($urandom);
            step();
            bits    = {bits[30:0], ser[0]};
            all_com = all_com & com[0];
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (got_vec(i) !== exp_vec(i)) begin
                    failures++;
                    $display("FAIL sync dut%0d edge=%0d got=%b exp=%b", i, e, got_vec(i), exp_vec(i));
                end
            end
        end
        checks++;
        if (bits !== {4{8'hBC}} || all_com !== 1'b1 || lrq[0] !== 1'b1) begin
            failures++;
            $display("FAIL sync_run got=%h com=%b lrq=%b exp=bcbcbcbc com=1 lrq=1", bits, all_com, lrq[0]);
        end
    endtask

    task automatic test_data();
        logic [7:0]  vals [3] = '{8'hFF, 8'hDD, 8'h03};
        logic [23:0] bits = '0;
        logic        any_com = 1'b0;
        for (int b = 0; b < 3; b++) begin
            in8      = 1'b1;
            in_data8 = vals[b];
            for (int k = 0; k < 8; k++) begin
                step();
                bits    = {bits[22:0], ser[0]};
                any_com = any_com | com[0];
                for (int i = 0; i < 2; i++) begin
                    checks++;
                    if (got_vec(i) !== exp_vec(i)) begin
                        failures++;
                        $display("FAIL data dut%0d edge=%0d got=%b exp=%b", i, e, got_vec(i), exp_vec(i));
                    end
                end
            end
        end
        checks++;
        if (bits !== 24'hFFDD03 || any_com !== 1'b0) begin
            failures++;
            $display("FAIL data_stream got=%h com=%b exp=ffdd03 com=0", bits, any_com);
        end
    endtask

    task automatic test_com_sub();
        logic [7:0] bits = '0;
        logic       all_com = 1'b1;
        in8      = 1'b0;
        in_data8 = 8'h55;
        for (int k = 0; k < 8; k++) begin
            step();
            bits    = {bits[6:0], ser[0]};
            all_com = all_com & com[0];
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (got_vec(i) !== exp_vec(i)) begin
                    failures++;
                    $display("FAIL com_sub dut%0d edge=%0d got=%b exp=%b", i, e, got_vec(i), exp_vec(i));
                end
            end
        end
        checks++;
        if (bits !== 8'hBC || all_com !== 1'b1) begin
            failures++;
            $display("FAIL com_sub_byte got=%h com=%b exp=bc com=1", bits, all_com);
        end
    endtask

    task automatic test_com_data();
        logic [7:0] bits = '0;
        logic       any_com = 1'b0;
        in8      = 1'b1;
        in_data8 = 8'hBC;
        for (int k = 0; k < 8; k++) begin
            step();
            bits    = {bits[6:0], ser[0]};
            any_com = any_com | com[0];
        end
        checks++;
        if (bits !== 8'hBC || any_com !== 1'b0) begin
            failures++;
            $display("FAIL com_as_data got=%h com=%b exp=bc com=0", bits, any_com);
        end
    endtask

    task automatic test_random();
        for (int b = 0; b < 24; b++) begin
            in8      = 1'($urandom_range(0, 3) != 0);
            in_data8 = 8'($urandom);
            for (int k = 0; k < 8; k++) begin
                step();
                for (int i = 0; i < 2; i++) begin
                    checks++;
                    if (got_vec(i) !== exp_vec(i)) begin
                        failures++;
                        $display("FAIL random dut%0d edge=%0d got=%b exp=%b", i, e, got_vec(i), exp_vec(i));
                    end
                end
                in8      = 1'($urandom_range(0, 1));
                in_data8 = 8'($urandom);
            end
        end
    endtask

    task automatic test_reset_mid();
        in8      = 1'b1;
        in_data8 = 8'hFF;
        for (int k = 0; k < 4; k++) step();
        // Short pulse placed between edges: outputs must drop without a clock edge.
        #2;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (got_vec(i) !== 4'b0000) begin
                failures++;
                $display("FAIL reset_mid dut%0d got=%b exp=0000", i, got_vec(i));
            end
        end
        #2;
        reset = 1'b1;
        model_reset();
        test_sync();
    endtask

    task automatic test_sync_count_1();
        reset = 1'b0;
        #3;
        reset = 1'b1;
        model_reset();
        in8 = 1'b0;
        step();
        checks++;
        if (act[1] !== 1'b1 || act[0] !== 1'b0) begin
            failures++;
            $display("FAIL sc1_active_edge1 got=%b%b exp=10 (dut1,dut0)", act[1], act[0]);
        end
        for (int k = 2; k <= 9; k++) begin
            in8      = 1'b1;
            in_data8 = 8'h96;
            step();
            checks++;
            if (lrq[1] !== (k == 8)) begin
                failures++;
                $display("FAIL sc1_load_req edge=%0d got=%b exp=%b", k, lrq[1], (k == 8));
            end
        end
        checks++;
        if ({ser[1], com[1], ser[0], com[0]} !== 4'b1011) begin
            failures++;
            $display("FAIL sc1_first_data got=%b exp=1011 (ser1,com1,ser0,com0)", {ser[1], com[1], ser[0], com[0]});
        end
    endtask

    initial begin
        test_reset();
        test_sync();
        test_data();
        test_com_sub();
        test_com_data();
        test_random();
        test_reset_mid();
        test_sync_count_1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
